multicycle_sequencer: RTL

// Central sequencer for the multicycle RISC-V datapath. Drives the shared 4-bit stage code `estado` consumed by the PC, fetch, decode, control, register-file, ALU and memory units.

---
 rtl/multicycle_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multicycle RISC-V datapath: drives the shared
// estado code, with run/step control, memory handshake timeout and retire count.
module multicycle_sequencer #(
   parameter int EX_WAIT     = 2,
   parameter int WB_WAIT     = 2,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_mode,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             instr_zero,
   input  logic             mem_ready,
   output logic [3:0]       estado,
   output logic             final_o,
   output logic             mem_err,
   output logic             step_ack,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IF    = 4'b0000,
      S_ID    = 4'b0001,
      S_EX    = 4'b0010,
      S_MEM   = 4'b0011,
      S_WB    = 4'b0100,
      S_AUX1  = 4'b0101,
      S_AUX3  = 4'b0110,
      S_AUX4  = 4'b0111,
      S_SUMPC = 4'b1000,
      S_FIM   = 4'b1001,
      S_HOLD  = 4'b1010,
      S_AUX5  = 4'b1100,
      S_AUX2  = 4'b1111
   } state_t;

   localparam logic [7:0] EX_LAST = 8'(EX_WAIT - 2);
   localparam logic [7:0] WB_LAST = 8'(WB_WAIT - 2);
   localparam logic [7:0] MEM_TO  = 8'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d, cnt_inc;
   logic             final_q, final_d;
   logic             mem_err_q, mem_err_d;
   logic             step_ack_q, step_ack_d;
   logic             busy_q, busy_d;
   logic             step_prev_q, step_prev_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             step_edge;
   logic             go;

   assign step_edge = step_req & ~step_prev_q;
   assign go        = run_mode & ~halt_req;
   assign cnt_inc   = cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_err_d   = mem_err_q;
      count_d     = count_q;
      step_ack_d  = 1'b0;
      step_prev_d = step_req;
      final_d     = (state_q == S_FIM);
      unique case (state_q)
         S_HOLD: begin
            if (go || (!run_mode && step_edge))
               state_d = S_IF;
         end
         S_IF: state_d = S_ID;
         S_ID: state_d = instr_zero ? S_AUX5 : S_EX;
         S_EX: begin
            state_d = S_AUX1;
            cnt_d   = '0;
         end
         S_AUX1: begin
            if (cnt_q == EX_LAST) state_d = S_AUX2;
            else                  cnt_d   = cnt_inc;
         end
         S_AUX2: begin
            state_d = S_MEM;
            cnt_d   = '0;
         end
         // ready is checked first so it beats a same-cycle timeout
         S_MEM: begin
            if (mem_ready) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == MEM_TO) begin
                  state_d   = S_FIM;
                  mem_err_d = 1'b1;
               end
            end
         end
         S_WB: begin
            state_d = S_AUX3;
            cnt_d   = '0;
         end
         S_AUX3: begin
            if (cnt_q == WB_LAST) state_d = S_AUX4;
            else                  cnt_d   = cnt_inc;
         end
         S_AUX4: state_d = S_AUX5;
         S_AUX5: state_d = instr_zero ? S_FIM : S_SUMPC;
         S_SUMPC: begin
            if (count_q != '1)
               count_d = count_q + CNT_W'(1);
            if (go) begin
               state_d = S_IF;
            end else begin
               state_d    = S_HOLD;
               step_ack_d = ~run_mode;
            end
         end
         S_FIM: state_d = S_FIM;
         default: state_d = S_HOLD;
      endcase
      busy_d = (state_d != S_HOLD) && (state_d != S_FIM);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_HOLD;
         cnt_q       <= '0;
         final_q     <= 1'b0;
         mem_err_q   <= 1'b0;
         step_ack_q  <= 1'b0;
         busy_q      <= 1'b0;
         step_prev_q <= 1'b1;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         final_q     <= final_d;
         mem_err_q   <= mem_err_d;
         step_ack_q  <= step_ack_d;
         busy_q      <= busy_d;
         step_prev_q <= step_prev_d;
         count_q     <= count_d;
      end
   end

   assign estado      = state_q;
   assign final_o     = final_q;
   assign mem_err     = mem_err_q;
   assign step_ack    = step_ack_q;
   assign busy        = busy_q;
   assign instr_count = count_q;

endmodule
